load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding byte/half/word request against a single-port data memory.
// Define LSU_RANGE_CHECK_EN to reject word indices >= MEM_DEPTH instead of wrapping them.
`timescale 1ns/1ps

module load_store_unit #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_q, state_d;
  logic        cap_we;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_offset;
  logic [15:0] cap_wdata;
  logic        req_err;
  logic        range_err;
  logic [29:0] req_word;

`ifdef LSU_RANGE_CHECK_EN
  assign req_word  = req_addr[31:2];
  assign range_err = ({2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH));
`else
  localparam logic [29:0] WORD_MASK = 30'(MEM_DEPTH - 1);
  assign req_word  = req_addr[31:2] & WORD_MASK;
  assign range_err = 1'b0;
`endif

  function automatic logic decode_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic err;
    case (f3)
      F3_B:    err = 1'b0;
      F3_H:    err = off[0];
      F3_W:    err = (off != 2'b00);
      F3_BU:   err = we;
      F3_HU:   err = we | off[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'h0, b};
      F3_HU:   r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane(s) of the word read back from memory.
  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [15:0] data,
                                              input logic [1:0] off, input logic half);
    logic [31:0] w;
    w = old;
    if (half) begin
      if (off[1]) w[31:16] = data;
      else        w[15:0]  = data;
    end else begin
      case (off)
        2'd0:    w[7:0]   = data[7:0];
        2'd1:    w[15:8]  = data[7:0];
        2'd2:    w[23:16] = data[7:0];
        default: w[31:24] = data[7:0];
      endcase
    end
    return w;
  endfunction

  assign req_err = decode_err(req_we, req_funct3, req_addr[1:0]) | range_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) begin
          if (req_err)                          state_d = RESP;
          else if (req_we && req_funct3 == F3_W) state_d = WRITE;
          else                                  state_d = READ;
        end
      end
      READ: begin
        mem_read = rst_n;
        state_d  = cap_we ? WRITE : RESP;
      end
      WRITE: begin
        // Gated by rst_n so an aborted store never reaches the memory.
        mem_write = rst_n;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = rst_n;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: capture and output registers are reset too, so the memory port reads as all-zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_we         <= 1'b0;
      cap_funct3     <= 3'b000;
      cap_offset     <= 2'b00;
      cap_wdata      <= 16'h0;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
      resp_err       <= 1'b0;
      resp_rdata     <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            cap_we      <= req_we;
            cap_funct3  <= req_funct3;
            cap_offset  <= req_addr[1:0];
            cap_wdata   <= req_wdata[15:0];
            mem_address <= {2'b00, req_word};
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_we && req_funct3 == F3_W) begin
              mem_write_data <= req_wdata;
            end
          end
        end
        READ: begin
          if (cap_we) begin
            mem_write_data <= merge_store(mem_read_data, cap_wdata, cap_offset, cap_funct3[0]);
          end else begin
            resp_rdata <= extract_load(mem_read_data, cap_offset, cap_funct3);
            resp_err   <= 1'b0;
          end
        end
        WRITE: begin
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized requests
// checked against a transaction-level model of the memory and lane rules.
`timescale 1ns/1ps

module tb_load_store_unit;

  localparam logic [31:0] DEPTH = 32'd1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  int          checks = 0;
  int          errors = 0;
  int          n_rd, n_wr, n_both, n_resp, n_bad_addr;
  logic [31:0] exp_word;
  logic [31:0] last_wdata;
  logic [31:0] got_rdata;
  logic        got_err;
  int          got_lat;

  load_store_unit #(.MEM_DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem_read ? mem[mem_address[9:0]] : 32'h0BAD_F00D;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, observe the memory port and apply any write.
  task automatic tick();
    @(negedge clk);
    if (mem_read) begin
      n_rd++;
      if (mem_address !== exp_word) n_bad_addr++;
    end
    if (mem_write) begin
      n_wr++;
      if (mem_address !== exp_word) n_bad_addr++;
      last_wdata = mem_write_data;
      mem[mem_address[9:0]] = mem_write_data;
    end
    if (mem_read && mem_write) n_both++;
    if (resp_valid) n_resp++;
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  task automatic clear_counts();
    n_rd = 0; n_wr = 0; n_both = 0; n_resp = 0; n_bad_addr = 0;
  endtask

  // One request from IDLE to the cycle after its response, checked against the model.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
    logic [31:0] bytes, sh, idx, old, val, mask, newword, e_rdata;
    logic        e_err, e_rd, e_wr;
    int          e_lat;

    bytes = (f3[1:0] == 2'd0) ? 32'd1 : (f3[1:0] == 2'd1) ? 32'd2 : 32'd4;
    e_err = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4) || ((addr % bytes) != 32'd0);
`ifdef LSU_RANGE_CHECK_EN
    if ((addr >> 2) >= DEPTH) e_err = 1'b1;
`endif
    idx = (addr >> 2) % DEPTH;
    sh  = (addr % 32'd4) * 32'd8;
    old = ref_mem[idx[9:0]];

    val = old >> sh;
    if (bytes == 32'd1) begin
      val = val & 32'hFF;
      if (f3 < 3'd4 && val >= 32'd128) val = val - 32'd256;
    end else if (bytes == 32'd2) begin
      val = val & 32'hFFFF;
      if (f3 < 3'd4 && val >= 32'd32768) val = val - 32'd65536;
    end

    if (bytes == 32'd4) newword = wdata;
    else begin
      mask    = ((32'd1 << (32'd8 * bytes)) - 32'd1) << sh;
      newword = (old & ~mask) | ((wdata << sh) & mask);
    end

    e_lat   = e_err ? 1 : (!we ? 2 : (bytes == 32'd4 ? 2 : 3));
    e_rd    = !e_err && (!we || bytes != 32'd4);
    e_wr    = !e_err && we;
    e_rdata = (e_err || we) ? 32'h0 : val;

    exp_word = idx;
    clear_counts();
    got_lat = 0;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);

    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    for (int c = 1; c <= 8 && got_lat == 0; c++) begin
      tick();
      if (c == 1) begin
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
      if (resp_valid) begin
        got_lat   = c;
        got_rdata = resp_rdata;
        got_err   = resp_err;
      end
    end

    check({tag, "_latency"}, 32'(got_lat), 32'(e_lat));
    check({tag, "_err"}, 32'(got_err), 32'(e_err));
    check({tag, "_rdata"}, got_rdata, e_rdata);
    check({tag, "_reads"}, 32'(n_rd), 32'(e_rd));
    check({tag, "_writes"}, 32'(n_wr), 32'(e_wr));
    check({tag, "_rd_wr_overlap"}, 32'(n_both), 32'd0);
    check({tag, "_bad_addr"}, 32'(n_bad_addr), 32'd0);
    if (e_wr) check({tag, "_wdata"}, last_wdata, newword);

    tick();
    check({tag, "_pulse_len"}, 32'(resp_valid), 32'd0);
    check({tag, "_rdata_hold"}, resp_rdata, e_rdata);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    if (e_wr) begin
      ref_mem[idx[9:0]] = newword;
      check({tag, "_mem_word"}, mem[idx[9:0]], newword);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    exp_word   = 32'h0;
    last_wdata = 32'h0;
    got_rdata  = 32'h0;
    got_err    = 1'b0;
    got_lat    = 0;
    clear_counts();
    for (int i = 0; i < 1024; i++) set_word(i, $urandom);

    // Reset state
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed loads and stores
    set_word(0, 32'hC0DE_1234);
    set_word(1, 32'h0000_80F0);
    set_word(2, 32'h0000_0062);
    set_word(3, 32'h1122_3344);

    run_txn(1'b0, 3'b010, 32'h8, 32'h0, "lw_0x8");
    check("lw_0x8_const", got_rdata, 32'h0000_0062);
    check("lw_0x8_lat_const", 32'(got_lat), 32'd2);

    run_txn(1'b0, 3'b000, 32'h4, 32'h0, "lb_0x4");
    check("lb_0x4_const", got_rdata, 32'hFFFF_FFF0);
    run_txn(1'b0, 3'b100, 32'h4, 32'h0, "lbu_0x4");
    check("lbu_0x4_const", got_rdata, 32'h0000_00F0);
    run_txn(1'b0, 3'b001, 32'h4, 32'h0, "lh_0x4");
    check("lh_0x4_const", got_rdata, 32'hFFFF_80F0);

    run_txn(1'b1, 3'b000, 32'hE, 32'h0000_00AB, "sb_0xe");
    check("sb_0xe_mem_const", mem[3], 32'h11AB_3344);
    check("sb_0xe_lat_const", 32'(got_lat), 32'd3);

    run_txn(1'b0, 3'b010, 32'h6, 32'h0, "lw_0x6");
    check("lw_0x6_err_const", 32'(got_err), 32'd1);
    run_txn(1'b1, 3'b001, 32'h5, 32'h1234_5678, "sh_0x5");
    check("sh_0x5_err_const", 32'(got_err), 32'd1);
    check("sh_0x5_nowrite", 32'(n_wr), 32'd0);

    run_txn(1'b0, 3'b010, 32'h1000, 32'h0, "lw_0x1000");
`ifdef LSU_RANGE_CHECK_EN
    check("lw_0x1000_err_const", 32'(got_err), 32'd1);
`else
    check("lw_0x1000_wrap_const", got_rdata, 32'hC0DE_1234);
`endif

    // Reset during the WRITE phase of a byte store
    clear_counts();
    exp_word   = 32'd3;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'hD;
    req_wdata  = 32'h0000_005A;
    tick();
    req_valid = 1'b0;
    tick();
    check("abort_in_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    n_wr = 0;
    n_resp = 0;
    tick();
    tick();
    check("abort_rst_ready", 32'(req_ready), 32'd0);
    check("abort_rst_mem_address", mem_address, 32'h0);
    check("abort_rst_mem_wdata", mem_write_data, 32'h0);
    check("abort_rst_resp_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    #1;
    check("abort_ready_after_rst", 32'(req_ready), 32'd1);
    tick();
    tick();
    tick();
    check("abort_no_write", 32'(n_wr), 32'd0);
    check("abort_no_resp", 32'(n_resp), 32'd0);
    set_word(3, 32'h1122_3344);

    // Randomized requests
    for (int i = 0; i < 200; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
      run_txn(we, f3, addr, $urandom, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
